// File: rtl/score_disp_pkg.sv
// ============================================================================
// Module : score_disp_pkg
// Brief  : Shared display-mode encoding and 7-segment constants for the
//          score display driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package score_disp_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        FLASH     = 2'd1,
        SHOW_HIGH = 2'd2
    } disp_mode_t;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ============================================================================
// Module : bcd_to_seg7
// Brief  : Combinational BCD digit to 7-segment decoder with blanking and a
//          dash for non-decimal codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_seg7
    import score_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            if (bcd > 4'd9) begin
                seg = SEG_DASH;
            end else begin
                seg = SEG_LUT[bcd];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/score_display_driver.sv
// ============================================================================
// Module : score_display_driver
// Brief  : 2-digit multiplexed 7-segment driver: live score in play, blinking
//          final score after game over, then the steady high score.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module score_display_driver
    import score_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_DIV   = 6000000,
    parameter int HOLD_BLINKS = 6
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_ones,
    input  logic       isGameComplete,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic [1:0] disp_mode
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HOLD_W  = $clog2(HOLD_BLINKS + 1);

    localparam logic [SCAN_W-1:0]  C_SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] C_BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
    localparam logic [HOLD_W-1:0]  C_HOLD      = HOLD_W'(HOLD_BLINKS);
    localparam logic [HOLD_W-1:0]  C_HOLD_ONE  = HOLD_W'(1);

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic               r_slot;
    logic               r_gc_d;
    logic [3:0]         r_shadow_tens;
    logic [3:0]         r_shadow_ones;
    disp_mode_t         r_state;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on;
    logic [HOLD_W-1:0]  r_half_cnt;
    logic [6:0]         r_seg;
    logic [1:0]         r_dig_en;

    logic               w_rise;
    logic               w_fall;
    disp_mode_t         w_state_next;
    logic [BLINK_W-1:0] w_blink_cnt_next;
    logic               w_blink_on_next;
    logic [HOLD_W-1:0]  w_half_cnt_next;
    logic [HOLD_W-1:0]  w_half_inc;
    logic               w_use_shadow;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;
    logic [3:0]         w_digit;
    logic               w_blank;
    logic [6:0]         w_seg;

    assign w_rise     = isGameComplete & ~r_gc_d;
    assign w_fall     = ~isGameComplete & r_gc_d;
    assign w_half_inc = r_half_cnt + C_HOLD_ONE;

    always_comb begin
        w_state_next     = r_state;
        w_blink_cnt_next = r_blink_cnt;
        w_blink_on_next  = r_blink_on;
        w_half_cnt_next  = r_half_cnt;
        case (r_state)
            PLAY: begin
                if (w_rise) begin
                    w_state_next     = FLASH;
                    w_blink_cnt_next = '0;
                    w_blink_on_next  = 1'b1;
                    w_half_cnt_next  = '0;
                end
            end
            FLASH: begin
                if (w_fall) begin
                    w_state_next = PLAY;
                end else if (r_blink_cnt == C_BLINK_MAX) begin
                    w_blink_cnt_next = '0;
                    w_blink_on_next  = ~r_blink_on;
                    w_half_cnt_next  = w_half_inc;
                    if (w_half_inc == C_HOLD) begin
                        w_state_next = SHOW_HIGH;
                    end
                end else begin
                    w_blink_cnt_next = r_blink_cnt + 1'b1;
                end
            end
            SHOW_HIGH: begin
                if (w_fall) begin
                    w_state_next = PLAY;
                end
            end
            default: begin
                w_state_next = PLAY;
            end
        endcase
    end

    // Output is built from the upcoming state so a state change lands on the
    // very next registered digit, while the slot keeps its 1-cycle latency.
    assign w_use_shadow = (w_state_next == FLASH);
    assign w_tens       = w_use_shadow ? r_shadow_tens : bcd_tens;
    assign w_ones       = w_use_shadow ? r_shadow_ones : bcd_ones;
    assign w_digit      = r_slot ? w_tens : w_ones;
    assign w_blank      = (r_slot && (w_tens == 4'd0)) ||
                          (w_use_shadow && !w_blink_on_next);

    bcd_to_seg7 u_dec (
        .bcd   (w_digit),
        .blank (w_blank),
        .seg   (w_seg)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_scan_cnt <= '0;
            r_slot     <= 1'b0;
            r_gc_d     <= 1'b0;
        end else begin
            r_gc_d <= isGameComplete;
            if (r_scan_cnt == C_SCAN_MAX) begin
                r_scan_cnt <= '0;
                r_slot     <= ~r_slot;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    // The tracker moves bcd and isGameComplete together, so the shadow skips
    // the rise cycle to keep the last in-play score.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_shadow_tens <= 4'd0;
            r_shadow_ones <= 4'd0;
        end else if ((r_state == PLAY) && !w_rise) begin
            r_shadow_tens <= bcd_tens;
            r_shadow_ones <= bcd_ones;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= PLAY;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
            r_half_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_blink_on  <= w_blink_on_next;
            r_half_cnt  <= w_half_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_seg    <= SEG_BLANK;
            r_dig_en <= 2'b00;
        end else begin
            r_seg    <= w_seg;
            r_dig_en <= r_slot ? 2'b10 : 2'b01;
        end
    end

    assign seg       = r_seg;
    assign dig_en    = r_dig_en;
    assign disp_mode = r_state;

endmodule

`default_nettype wire

// File: tb/tb_score_display_driver.sv
// ============================================================================
// Module : tb_score_display_driver
// Brief  : Self-checking bench for score_display_driver against a cycle-count
//          reference model of the display rules.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_display_driver;

    localparam int SCAN_DIV    = 4;
    localparam int BLINK_DIV   = 8;
    localparam int HOLD_BLINKS = 4;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic [3:0] bcd_tens = 4'd0;
    logic [3:0] bcd_ones = 4'd0;
    logic       isGameComplete = 1'b0;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic [1:0] disp_mode;

    score_display_driver #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_DIV   (BLINK_DIV),
        .HOLD_BLINKS (HOLD_BLINKS)
    ) dut (
        .clk            (clk),
        .nRst           (nRst),
        .bcd_tens       (bcd_tens),
        .bcd_ones       (bcd_ones),
        .isGameComplete (isGameComplete),
        .seg            (seg),
        .dig_en         (dig_en),
        .disp_mode      (disp_mode)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [6:0] lut [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: edges since release, mode 0/1/2, age of the flash.
    int m_n, m_mode, m_age, m_gc_prev;
    int m_prev_t, m_prev_o, m_frozen_t, m_frozen_o;
    int flash_run, prev_obs_mode;

    function automatic logic [6:0] ref_seg(input int v);
        if (v > 9) return 7'h40;
        return lut[v];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_mode = 0; m_age = 0; m_gc_prev = 0;
        m_prev_t = 0; m_prev_o = 0; m_frozen_t = 0; m_frozen_o = 0;
        flash_run = 0; prev_obs_mode = 0;
    endtask

    task automatic model_step();
        bit rise, fall;
        m_n++;
        rise = isGameComplete && (m_gc_prev == 0);
        fall = !isGameComplete && (m_gc_prev == 1);
        case (m_mode)
            0: if (rise) begin
                m_mode = 1; m_age = 0;
                m_frozen_t = m_prev_t; m_frozen_o = m_prev_o;
            end
            1: if (fall) m_mode = 0;
               else begin
                   m_age++;
                   if (m_age == HOLD_BLINKS * BLINK_DIV) m_mode = 2;
               end
            default: if (fall) m_mode = 0;
        endcase
        m_gc_prev = isGameComplete ? 1 : 0;
        m_prev_t = bcd_tens;
        m_prev_o = bcd_ones;
    endtask

    task automatic check_outputs();
        int slot, t, o;
        logic [6:0] exp_seg;
        slot = ((m_n - 1) / SCAN_DIV) % 2;
        if (m_mode == 1) begin t = m_frozen_t; o = m_frozen_o; end
        else begin t = bcd_tens; o = bcd_ones; end
        if (m_mode == 1 && ((m_age / BLINK_DIV) % 2) == 1) exp_seg = 7'h00;
        else if (slot == 1) exp_seg = (t == 0) ? 7'h00 : ref_seg(t);
        else exp_seg = ref_seg(o);
        chk("seg", seg, exp_seg);
        chk("dig_en", dig_en, (slot == 1) ? 2'b10 : 2'b01);
        chk("disp_mode", disp_mode, m_mode);
        chk("dig_en_onehot", (dig_en == 2'b01 || dig_en == 2'b10 || dig_en == 2'b00), 1);
        if (disp_mode == 2'd1) flash_run++;
        else begin
            if (prev_obs_mode == 1 && disp_mode == 2'd2)
                chk("flash_len_min", (flash_run >= HOLD_BLINKS * BLINK_DIV), 1);
            flash_run = 0;
        end
        prev_obs_mode = disp_mode;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic set_bcd(input int t, input int o);
        bcd_tens = 4'(t);
        bcd_ones = 4'(o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        set_bcd(2, 7);
        repeat (2) @(negedge clk);
        chk("rst_seg", seg, 7'h00);
        chk("rst_dig_en", dig_en, 2'b00);
        chk("rst_mode", disp_mode, 2'd0);

        nRst = 1'b1;
        run(16);
        set_bcd(0, 5); run(8);
        set_bcd(0, 0); run(8);

        for (int i = 0; i < 24; i++) begin
            set_bcd($urandom_range(0, 15), $urandom_range(0, 15));
            tick();
        end

        // Game over with the tracker's final update landing in the same cycle
        set_bcd(1, 4); run(3);
        set_bcd(3, 1); isGameComplete = 1'b1;
        tick();
        chk("enter_flash", disp_mode, 2'd1);
        run(39);
        chk("show_high", disp_mode, 2'd2);
        isGameComplete = 1'b0;
        tick();
        chk("fall_to_play", disp_mode, 2'd0);
        run(4);

        // Abort a flash partway through
        set_bcd($urandom_range(0, 9), $urandom_range(0, 9)); run(3);
        set_bcd($urandom_range(0, 9), $urandom_range(0, 9)); isGameComplete = 1'b1;
        run(10);
        isGameComplete = 1'b0;
        tick();
        chk("abort_flash", disp_mode, 2'd0);
        run(20);

        set_bcd(10, 15); run(8);

        for (int g = 0; g < 4; g++) begin
            int play_len, hold_len;
            play_len = $urandom_range(3, 12);
            hold_len = $urandom_range(5, 45);
            for (int i = 0; i < play_len; i++) begin
                set_bcd($urandom_range(0, 9), $urandom_range(0, 9));
                tick();
            end
            set_bcd($urandom_range(0, 9), $urandom_range(0, 9));
            isGameComplete = 1'b1;
            run(hold_len);
            isGameComplete = 1'b0;
            run(3);
        end

        // Asynchronous reset in the middle of SHOW_HIGH
        set_bcd(1, 2); run(3);
        set_bcd(9, 9); isGameComplete = 1'b1;
        run(36);
        chk("pre_reset_mode", disp_mode, 2'd2);
        #2;
        nRst = 1'b0;
        #1;
        chk("async_rst_seg", seg, 7'h00);
        chk("async_rst_dig_en", dig_en, 2'b00);
        chk("async_rst_mode", disp_mode, 2'd0);
        repeat (2) @(negedge clk);
        model_reset();
        nRst = 1'b1;
        tick();
        chk("reenter_flash", disp_mode, 2'd1);
        chk("reenter_shadow0", seg, 7'h3F);
        run(10);
        isGameComplete = 1'b0;
        run(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
